// File: rtl/tdc_pkg.sv
// Shared constants, state encodings and frame byte helper for the TDC readout path.
package tdc_pkg;

    localparam logic [7:0] TDC_SYNC_BYTE   = 8'hA5;
    localparam int         TDC_FRAME_BYTES = 4;
    localparam int         TDC_CODE_WIDTH  = 16;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_LOAD,
        FR_SEND
    } frame_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } bit_state_t;

    // Byte idx of the frame: sync, code high, code low, xor checksum.
    function automatic logic [7:0] frame_byte(input logic [TDC_CODE_WIDTH-1:0] code,
                                              input logic [1:0]                idx);
        case (idx)
            2'd0:    frame_byte = TDC_SYNC_BYTE;
            2'd1:    frame_byte = code[15:8];
            2'd2:    frame_byte = code[7:0];
            default: frame_byte = TDC_SYNC_BYTE ^ code[15:8] ^ code[7:0];
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Purpose: serialise one byte as UART 8N1 (start, 8 data LSB first, stop).
// Latency: o_tx follows the internal bit state by one registered cycle.
// Backpressure: i_start is taken in idle or in the last stop cycle (o_done), enabling gapless bytes.
module uart_tx_byte
    import tdc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_tx,
    output logic       o_done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    bit_state_t    st;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign o_done = (st == TX_STOP) && (cnt == '0);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            st      <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            o_tx    <= 1'b1;
        end else begin
            o_tx <= (st == TX_START) ? 1'b0 : (st == TX_DATA) ? shreg[0] : 1'b1;
            case (st)
                TX_IDLE: begin
                    if (i_start) begin
                        st    <= TX_START;
                        cnt   <= CNT_MAX;
                        shreg <= i_byte;
                    end
                end
                TX_START: begin
                    if (cnt == '0) begin
                        st      <= TX_DATA;
                        cnt     <= CNT_MAX;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (cnt == '0) begin
                        cnt   <= CNT_MAX;
                        shreg <= shreg >> 1;
                        if (bit_idx == 3'd7) begin
                            st <= TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TX_STOP: begin
                    if (cnt == '0) begin
                        // Chain straight into the next start bit when one is queued.
                        if (i_start) begin
                            st    <= TX_START;
                            cnt   <= CNT_MAX;
                            shreg <= i_byte;
                        end else begin
                            st <= TX_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: st <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tdc_readout.sv
// Purpose: buffer TDC codes in a FIFO and send each as a 4-byte checksummed UART frame.
// Latency: push at edge N -> pop N+1, LOAD N+2, start bit on o_tx after N+3.
// Backpressure: none upstream; pushes while full are dropped and flagged in sticky o_overflow.
module tdc_readout
    import tdc_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_valid,
    input  logic [DATA_WIDTH-1:0]       i_data,
    input  logic                        i_enable,
    output logic                        o_tx,
    output logic                        o_busy,
    output logic                        o_overflow,
    output logic [$clog2(FIFO_DEPTH):0] o_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] LAST_IDX = 2'(TDC_FRAME_BYTES - 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wptr, rptr, wptr_n, rptr_n, level;
    logic                  full, push, pop;

    frame_state_t          state;
    logic [1:0]            idx;
    logic [DATA_WIDTH-1:0] word;
    logic                  tx_start, tx_done, frame_end, idle_next;
    logic [7:0]            tx_byte;

    // Full comes from registered pointers, so a same-cycle pop never frees room.
    assign level   = wptr - rptr;
    assign o_level = level;
    assign full    = (level == (AW+1)'(FIFO_DEPTH));
    assign push    = i_valid && i_enable && !full;
    assign pop     = (state == FR_IDLE) && (level != '0);
    assign wptr_n  = wptr + {{AW{1'b0}}, push};
    assign rptr_n  = rptr + {{AW{1'b0}}, pop};

    assign frame_end = (state == FR_SEND) && tx_done && (idx == LAST_IDX);
    assign idle_next = ((state == FR_IDLE) && !pop) || frame_end;

    always_comb begin
        tx_start = 1'b0;
        tx_byte  = TDC_SYNC_BYTE;
        if (state == FR_LOAD) begin
            tx_start = 1'b1;
        end else if ((state == FR_SEND) && tx_done && (idx != LAST_IDX)) begin
            tx_start = 1'b1;
            tx_byte  = frame_byte(word, idx + 2'd1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            wptr       <= '0;
            rptr       <= '0;
            state      <= FR_IDLE;
            idx        <= '0;
            word       <= '0;
            o_busy     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            wptr   <= wptr_n;
            rptr   <= rptr_n;
            o_busy <= !idle_next || (wptr_n != rptr_n);
            if (i_valid && i_enable && full) begin
                o_overflow <= 1'b1;
            end
            case (state)
                FR_IDLE: begin
                    if (pop) begin
                        word  <= mem[rptr[AW-1:0]];
                        state <= FR_LOAD;
                    end
                end
                FR_LOAD: begin
                    state <= FR_SEND;
                    idx   <= '0;
                end
                FR_SEND: begin
                    if (tx_done) begin
                        if (idx == LAST_IDX) begin
                            state <= FR_IDLE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                default: state <= FR_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_start(tx_start),
        .i_byte (tx_byte),
        .o_tx   (o_tx),
        .o_done (tx_done)
    );

endmodule
